// File: rtl/pwm_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_stream_gen
// Purpose  : Multi-channel PWM generator fed by a valid/ready sample stream.
//            Signed samples are converted to offset-binary duty values and
//            double-buffered per channel (pending -> active). The active duty
//            only changes at the period boundary, so a period is never cut
//            short or stretched. A boundary with no fresh sample raises a
//            one-cycle underrun pulse aligned with period_start_o.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   CENTER_ALIGNED_EN  defined   -> triangle counter (0..MAX..1), period
//                                   2^(COUNTER_WIDTH+1)-2 cycles.
//                      undefined -> edge-aligned sawtooth, period
//                                   2^COUNTER_WIDTH cycles.
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_WIDTH    width of each signed input sample (>= COUNTER_WIDTH)
//   COUNTER_WIDTH PWM resolution in bits
//   NUM_CH        number of PWM channels sharing one counter
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   s_data_i       in   packed signed samples, ch k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_valid_i      in   s_data_i holds a sample set for all channels
//   s_ready_o      out  pending buffer empty, sample set can be accepted
//   pwm_out_o      out  registered PWM outputs, one per channel
//   period_start_o out  one-cycle pulse on the first pwm_out_o cycle of a period
//   underrun_o     out  one-cycle pulse when a period starts without fresh data
// ============================================================================
module pwm_stream_gen #(
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 10,
  parameter int NUM_CH        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  output logic [NUM_CH-1:0]            pwm_out_o,
  output logic                         period_start_o,
  output logic                         underrun_o
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = COUNTER_WIDTH;

  localparam logic [CW-1:0] C_CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] C_CNT_ZERO = '0;
  // Midscale duty; also the mask that flips the MSB of a two's-complement
  // value to turn it into offset binary.
  localparam logic [CW-1:0] C_DUTY_MID = CW'(1) << (CW - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  if (DATA_WIDTH < COUNTER_WIDTH) begin : g_bad_width
    $error("pwm_stream_gen: DATA_WIDTH must be >= COUNTER_WIDTH");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_CH*CW-1:0] duty_q, duty_d;
  logic [NUM_CH*CW-1:0] pending_q, pending_d;
  logic                 pending_full_q, pending_full_d;
  logic                 ready_q, ready_d;
  logic                 miss_q, miss_d;
  logic [NUM_CH-1:0]    pwm_q, pwm_d;
  logic                 period_start_q, period_start_d;
  logic                 underrun_q, underrun_d;

  logic [NUM_CH*CW-1:0] w_duty_new;
  logic                 w_xfer;
  logic                 w_boundary;
  // Only the top COUNTER_WIDTH bits of each sample are used; the rest are
  // deliberately discarded (no rounding).
  logic                 w_unused_data;

  assign w_unused_data = ^s_data_i;
  assign w_xfer        = s_valid_i & ready_q;

  // --------------------------------------------------------------------------
  // Per-channel conversion and compare
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Top CW bits of the sample with the MSB inverted: most negative -> 0,
    // zero -> midscale, most positive -> MAX.
    assign w_duty_new[k*CW +: CW] = s_data_i[k*DW + (DW - CW) +: CW] ^ C_DUTY_MID;
    // Unsigned compare against the current count; registered below, so the
    // output lags cnt_q by one cycle, as does period_start_o.
    assign pwm_d[k] = (cnt_q < duty_q[k*CW +: CW]);
  end

  // --------------------------------------------------------------------------
  // Counter and boundary detection
  // --------------------------------------------------------------------------
`ifdef CENTER_ALIGNED_EN
  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  dir_e dir_q, dir_d;

  // Triangle: 0,1,..,MAX,MAX-1,..,1 then back to 0. The value 0 is visited
  // once per period, which is what makes it usable as the period marker.
  always_comb begin
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (dir_q == DIR_UP) begin
      if (cnt_q == C_CNT_MAX) begin
        dir_d = DIR_DOWN;
        cnt_d = cnt_q - C_CNT_ONE;
      end else begin
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q - C_CNT_ONE;
      if (cnt_q == C_CNT_ONE) begin
        dir_d = DIR_UP;
      end
    end
  end

  assign w_boundary = (dir_q == DIR_DOWN) && (cnt_q == C_CNT_ONE);
`else
  always_comb begin
    cnt_d = cnt_q + C_CNT_ONE;
  end

  assign w_boundary = (cnt_q == C_CNT_MAX);
`endif

  // --------------------------------------------------------------------------
  // Double buffer, handshake and output next-state
  // --------------------------------------------------------------------------
  always_comb begin
    duty_d         = duty_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    miss_d         = 1'b0;

    if (w_boundary) begin
      if (pending_full_q) begin
        // ready_q is low while pending is full, so no transfer can collide
        // with this load.
        duty_d         = pending_q;
        pending_full_d = 1'b0;
      end else if (w_xfer) begin
        // Sample arriving exactly on the boundary skips the pending stage
        // and counts as fresh for the new period.
        duty_d = w_duty_new;
      end else begin
        miss_d = 1'b1;
      end
    end else if (w_xfer) begin
      pending_d      = w_duty_new;
      pending_full_d = 1'b1;
    end

    ready_d        = ~pending_full_d;
    period_start_d = (cnt_q == C_CNT_ZERO);
    // miss_q is high during the cnt==0 cycle, so registering it once more
    // lines the pulse up with period_start_o.
    underrun_d     = miss_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= C_CNT_ZERO;
      duty_q         <= {NUM_CH{C_DUTY_MID}};
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      ready_q        <= 1'b0;
      // The period that begins as reset releases has no sample behind it,
      // so it is reported as an underrun like any other starved period.
      miss_q         <= 1'b1;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      ready_q        <= ready_d;
      miss_q         <= miss_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

`ifdef CENTER_ALIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign s_ready_o      = ready_q;
  assign pwm_out_o      = pwm_q;
  assign period_start_o = period_start_q;
  assign underrun_o     = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_stream_gen
// Purpose  : Self-checking bench for pwm_stream_gen (edge-aligned build,
//            DATA_WIDTH=8, COUNTER_WIDTH=4, NUM_CH=2). The stimulus pushes the
//            expected per-period duty/underrun into a scoreboard queue; a
//            monitor captures each 16-cycle period and compares on its end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_stream_gen;

  localparam int DW  = 8;
  localparam int CW  = 4;
  localparam int NCH = 2;
  localparam int PER = 16;

  logic               clk     = 1'b0;
  logic               rst     = 1'b1;
  logic [NCH*DW-1:0]  s_data  = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [NCH-1:0]     pwm_out;
  logic               period_start;
  logic               underrun;

  always #5 clk = ~clk;

  pwm_stream_gen #(
    .DATA_WIDTH    (DW),
    .COUNTER_WIDTH (CW),
    .NUM_CH        (NCH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .pwm_out_o      (pwm_out),
    .period_start_o (period_start),
    .underrun_o     (underrun)
  );

  typedef struct {
    int d0;
    int d1;
    bit ur;
  } exp_t;

  exp_t sb[$];

  int checks    = 0;
  int errors    = 0;
  int ncyc      = 0;
  int last_sync = -1;
  int pnum      = 0;

  bit           mon_en   = 1'b0;
  int           idx      = -1;
  logic [PER-1:0] pat0, pat1;
  bit           ur_start, ur_stray;

  always @(posedge clk) ncyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
    end
  endtask

  function automatic logic [PER-1:0] pat_of(input int d);
    logic [PER-1:0] p;
    p = '0;
    for (int i = 0; i < PER; i++) p[i] = (i < d);
    return p;
  endfunction

  task automatic push(input int d0, input int d1, input bit ur);
    exp_t e;
    e.d0 = d0;
    e.d1 = d1;
    e.ur = ur;
    sb.push_back(e);
  endtask

  task automatic end_period();
    exp_t e;
    pnum++;
    if (sb.size() == 0) begin
      chk($sformatf("p%0d_sb_entry", pnum), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("p%0d_pat_ch0", pnum), 32'(pat0), 32'(pat_of(e.d0)));
      chk($sformatf("p%0d_pat_ch1", pnum), 32'(pat1), 32'(pat_of(e.d1)));
      // {pulse at period start, pulse anywhere else}
      chk($sformatf("p%0d_underrun", pnum), {30'd0, ur_start, ur_stray}, {30'd0, e.ur, 1'b0});
    end
  endtask

  // Period monitor: bit i of pat is pwm_out on the i-th cycle of the period.
  always @(negedge clk) begin
    if (!mon_en) begin
      idx = -1;
    end else begin
      if (period_start) begin
        if (idx == PER) end_period();
        else if (idx > 0) chk("period_len_short", idx, PER);
        idx      = 0;
        ur_start = underrun;
        ur_stray = 1'b0;
        pat0     = '0;
        pat1     = '0;
      end else if (underrun) begin
        ur_stray = 1'b1;
      end
      if (idx >= 0) begin
        if (idx < PER) begin
          pat0[idx] = pwm_out[0];
          pat1[idx] = pwm_out[1];
          idx++;
        end else begin
          chk("period_len_long", idx + 1, PER);
          idx = -1;
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge carrying a period_start pulse not already consumed.
  task automatic sync_start();
    for (int n = 0; n < 3 * PER; n++) begin
      if (period_start && (ncyc != last_sync)) begin
        last_sync = ncyc;
        return;
      end
      @(negedge clk);
    end
    chk("period_start_timeout", 32'd0, 32'd1);
  endtask

  // Holds s_valid until the DUT is ready; waited = negedges spent waiting.
  task automatic send(input logic [NCH*DW-1:0] d, input int budget, output int waited);
    s_valid = 1'b1;
    s_data  = d;
    waited  = -1;
    for (int n = 0; n <= budget; n++) begin
      if (s_ready) begin
        waited = n;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("send_accepted", 32'(waited >= 0), 32'd1);
  endtask

  initial begin
    int w;

    // Reset state
    rst = 1'b1;
    wait_n(3);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_period_start", 32'(period_start), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    mon_en = 1'b1;
    rst    = 1'b0;

    // P1: midscale, starved
    sync_start();
    push(8, 8, 1'b1);
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    // P2: starved; ch0=0x7F ch1=0x80 arrives mid-period
    sync_start();
    push(8, 8, 1'b1);
    wait_n(4);
    send(16'h807F, 2, w);
    chk("ready_low_pending", 32'(s_ready), 32'd0);

    // P3: 0x7F -> 15, 0x80 -> 0. Then set A accepted, set B held.
    sync_start();
    push(15, 0, 1'b0);
    wait_n(2);
    send(16'h4000, 2, w);
    chk("ready_low_full", 32'(s_ready), 32'd0);
    send(16'h3FC0, 20, w);
    chk("held_accept_wait", w, 32'd12);

    // P4: A (ch0 0x00 -> 8, ch1 0x40 -> 12)
    sync_start();
    push(8, 12, 1'b0);

    // P5: B (ch0 0xC0 -> 4, ch1 0x3F -> 11); then C sent on the boundary cycle
    sync_start();
    push(4, 11, 1'b0);
    wait_n(14);
    chk("ready_before_bypass", 32'(s_ready), 32'd1);
    send(16'hA040, 0, w);

    // P6: C bypassed (ch0 0x40 -> 12, ch1 0xA0 -> 2), pending still empty
    sync_start();
    push(12, 2, 1'b0);
    chk("ready_after_bypass", 32'(s_ready), 32'd1);

    // P7: duty holds, starved; load pending then reset mid-period
    sync_start();
    push(12, 2, 1'b1);
    wait_n(3);
    send(16'h7F7F, 2, w);
    wait_n(1);
    mon_en = 1'b0;
    rst    = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rstmid_pwm", 32'(pwm_out), 32'd0);
    chk("rstmid_period_start", 32'(period_start), 32'd0);
    chk("rstmid_underrun", 32'(underrun), 32'd0);
    chk("rstmid_ready", 32'(s_ready), 32'd0);
    mon_en = 1'b1;
    rst    = 1'b0;

    // P8/P9: pending sample gone, midscale and starved
    sync_start();
    push(8, 8, 1'b1);
    sync_start();
    push(8, 8, 1'b1);
    sync_start();
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_stream_gen.md
Name: pwm_stream_gen

Overview:
- Multi-channel, parametrised PWM generator driven by a valid/ready sample stream.
- Converts two's-complement samples to offset-binary duty values, double-buffered per channel.
- Duty changes are applied only at the PWM period boundary. Underrun is signalled when no new sample is waiting at the boundary.
- Sits between the demodulator/decimator output and the board-level audio PWM pins.

Parameters:
- DATA_WIDTH, 12, width of each signed input sample; must be >= COUNTER_WIDTH.
- COUNTER_WIDTH, 10, PWM resolution; the edge-aligned period is 2^COUNTER_WIDTH cycles.
- NUM_CH, 2, number of independent PWM channels sharing one counter.

Ports:
- clk, in, 1, single system clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- s_data, in, NUM_CH*DATA_WIDTH, packed signed samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_valid, in, 1, s_data holds a sample set for all channels.
- s_ready, out, 1, pending buffer is empty and can accept a sample set.
- pwm_out, out, NUM_CH, registered PWM outputs.
- period_start, out, 1, one-cycle pulse aligned with the first pwm_out cycle of each period.
- underrun, out, 1, one-cycle pulse when a period starts without a fresh sample.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. Nothing is asynchronous.
- Reset values:
  - cnt = 0.
  - duty_active[k] = 2^(COUNTER_WIDTH-1), i.e. midscale, 50 %.
  - pending empty.
  - pwm_out = 0, period_start = 0, underrun = 0.
  - s_ready = 0 while rst is high.
- Duty conversion (per channel): take the top COUNTER_WIDTH bits of the sample and invert their MSB.
  - Result: most negative sample gives duty 0, zero gives midscale, most positive gives 2^COUNTER_WIDTH-1.
  - No rounding; lower bits are discarded.
- Counter (edge-aligned): cnt increments every cycle and wraps from MAX = 2^COUNTER_WIDTH-1 to 0.
- Outputs:
  - pwm_out[k] <= (cnt < duty_active[k]). This is an unsigned compare, registered, so there is 1 cycle latency from cnt.
  - Duty 0 gives constant low. Duty MAX gives high for MAX cycles and low for 1 cycle.
  - period_start <= (cnt == 0), so it is aligned with pwm_out.
- Handshake:
  - s_ready = !pending_full, driven from a register.
  - A transfer occurs when s_valid && s_ready. The sample set is converted and stored in pending, and pending becomes full.
  - s_data may change freely when no transfer occurs.
- Boundary, i.e. the clock edge at which cnt goes from MAX to 0:
  - Pending full: duty_active <= pending; pending empties; s_ready = 1 on the next cycle.
  - Pending empty and a transfer on this same cycle: the new sample bypasses pending straight into duty_active. Pending stays empty and no underrun is raised.
  - Pending empty and no transfer: duty_active holds. underrun pulses high for 1 cycle, aligned with period_start.
- New duty takes effect from the first pwm_out cycle of the new period. There is never a mid-period change.
- Pending full with no boundary: s_ready stays 0 and s_valid is ignored. The producer must hold its data.
- Reset mid-period: outputs are forced to their reset values on the next edge. The pending sample is discarded. The counter restarts at 0.

Optional Feature:
- CENTER_ALIGNED_EN defined:
  - cnt is a triangle: 0 up to MAX, then down to 1, then repeats. Period is 2^(COUNTER_WIDTH+1)-2 cycles.
  - Compare rule is unchanged; high time is 2*duty-1 cycles for duty >= 1 and 0 for duty 0.
  - The boundary is the edge from cnt=1 (counting down) to cnt=0. period_start and underrun are asserted at cnt==0.
- CENTER_ALIGNED_EN undefined: edge-aligned sawtooth as described above.
- Handshake and conversion are identical in both modes.

Test Plan (DATA_WIDTH=8, COUNTER_WIDTH=4, NUM_CH=2 unless stated):
- Reset, then no samples -> both pwm_out show 8 high / 8 low per 16-cycle period; underrun pulses at every period_start; s_ready = 1 after reset.
- Send ch0=0x7F, ch1=0x80 mid-period -> current period is unchanged. From the next period_start, ch0 is high 15 of 16 cycles and ch1 is constant low. No underrun on that boundary.
- Send one sample set, then hold s_valid high with a second set -> s_ready falls after the first transfer. The second set is accepted the cycle after the boundary. Each applies in consecutive periods.
- Present a sample only on the boundary cycle (cnt=15) with pending empty -> the value applies in the very next period and no underrun pulse occurs.
- Assert rst for 1 cycle with a sample pending, mid-period -> pwm_out=0 next cycle; the pending sample is lost; after release, midscale duty resumes from cnt=0.
- With CENTER_ALIGNED_EN, input 0x00 -> 30-cycle period, 15 high cycles centred on the counter minimum; 0x7F -> 29 high cycles; 0x80 -> 0 high cycles.
